product_display: RTL and testbench



---
 rtl/display_pkg.sv | 53 +++++
 rtl/bin_to_bcd_seq.sv | 71 +++++++
 rtl/product_display.sv | 100 ++++++++++
 tb/tb_product_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the product display slice.
//   state_t      : conversion FSM states
//   SEG_0..SEG_9 : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   AN_OFF       : all anodes off
//   seg_decode() : BCD nibble to segment pattern (non-decimal values go dark)
//   add3()       : double-dabble nibble correction
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // 4-bit wrap-around add; a corrected digit never carries into its neighbour.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD.
//   clk   : system clock, rising edge
//   CLR   : synchronous active-high reset, aborts any conversion
//   start : begin converting bin (ignored unless idle)
//   bin   : binary input, sampled on the start edge
//   bcd   : {hundreds, tens, ones}; final only while valid is high
//   valid : one-cycle pulse in WRITE, bcd is the finished result
//   busy  : high from the start edge until the WRITE cycle ends
module bin_to_bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        CLR,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        busy
);

  state_t      state, state_n;
  logic [19:0] work, work_n;
  logic [2:0]  cnt, cnt_n;
  logic [19:0] adj;

  always_ff @(posedge clk) begin
    if (CLR) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      work  <= work_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    adj = {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    valid   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_n  = {12'b0, bin};
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        work_n = {adj[18:0], 1'b0};
        cnt_n  = cnt + 3'd1;
        if (cnt == 3'd7) state_n = WRITE;
      end
      WRITE: begin
        valid   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign bcd  = work[19:8];

endmodule

// File: rtl/product_display.sv
// Captures the multiplier product on each rising edge of done, converts it
// to BCD and shows it on a multiplexed, active-low 4-digit seven-segment
// display with leading-zero blanking.
//   clk  : system clock, rising edge
//   CLR  : synchronous active-high reset
//   P    : 8-bit product
//   done : product-ready level; only its 0->1 transition starts a conversion
//   seg  : segments {g,f,e,d,c,b,a}, active low, registered
//   an   : anodes, active low, an[0] = ones digit, registered
//   busy : conversion in progress
module product_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       CLR,
  input  logic [7:0] P,
  input  logic       done,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic          done_q;
  logic          start;
  logic [11:0]   bcd;
  logic          valid;
  logic [11:0]   bcd_disp;
  logic [11:0]   disp_n;
  logic [RW-1:0] refresh;
  logic [1:0]    digit;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;

  assign start = done & ~done_q & ~busy;

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .CLR   (CLR),
    .start (start),
    .bin   (P),
    .bcd   (bcd),
    .valid (valid),
    .busy  (busy)
  );

  // Decode from the value being written so a fresh result reaches the
  // outputs on the same edge that bcd_disp takes it.
  assign disp_n = valid ? bcd : bcd_disp;
  assign wrap   = (refresh == RW'(REFRESH_DIV - 1));

  always_comb begin
    nib   = disp_n[3:0];
    blank = 1'b0;
    an_n  = 4'b1110;
    case (digit)
      2'd1: begin
        nib   = disp_n[7:4];
        blank = (disp_n[11:8] == 4'd0) && (disp_n[7:4] == 4'd0);
        an_n  = 4'b1101;
      end
      2'd2: begin
        nib   = disp_n[11:8];
        blank = (disp_n[11:8] == 4'd0);
        an_n  = 4'b1011;
      end
      default: ;
    endcase
    seg_n = seg_decode(nib);
    if (blank) begin
      seg_n = SEG_OFF;
      an_n  = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      done_q   <= 1'b0;
      bcd_disp <= '0;
      refresh  <= '0;
      digit    <= '0;
      seg      <= SEG_0;
      an       <= 4'b1110;
    end else begin
      done_q   <= done;
      bcd_disp <= disp_n;
      refresh  <= wrap ? '0 : refresh + RW'(1);
      if (wrap) digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
      seg      <= seg_n;
      an       <= an_n;
    end
  end

endmodule

// File: tb/tb_product_display.sv
module tb_product_display;

  logic       clk = 1'b0;
  logic       CLR;
  logic [7:0] P;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // display observation results
  logic       seen_h, seen_t, seen_o;
  logic [6:0] seg_h, seg_t, seg_o;
  int         bad;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;

  product_display #(.REFRESH_DIV(4)) dut (
    .clk  (clk),
    .CLR  (CLR),
    .P    (P),
    .done (done),
    .seg  (seg),
    .an   (an),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Sample 16 cycles (more than one full 3-slot scan) and record what each
  // anode showed; blank slots must be fully dark, an[3] never active.
  task automatic observe();
    seen_h = 0; seen_t = 0; seen_o = 0;
    seg_h = '1; seg_t = '1; seg_o = '1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin seen_o = 1; seg_o = seg; end
        4'b1101: begin seen_t = 1; seg_t = seg; end
        4'b1011: begin seen_h = 1; seg_h = seg; end
        4'b1111: if (seg !== 7'b1111111) bad++;
        default: bad++;
      endcase
    end
  endtask

  // Pulse done for one clock with product p; returns busy-high cycle count.
  task automatic convert(input logic [7:0] p, output int bcount);
    bcount = 0;
    @(negedge clk);
    P = p; done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done = 1'b0;
      if (busy) bcount++;
      else if (bcount > 0) break;
    end
  endtask

  task automatic test_reset();
    CLR = 1'b1; done = 1'b0; P = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an); end
    checks++; if (seg !== S0) begin errors++; $display("FAIL reset_seg got=%b exp=%b", seg, S0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    CLR = 1'b0;
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b001) begin errors++; $display("FAIL idle_slots got=%b exp=001", {seen_h, seen_t, seen_o}); end
    checks++; if (seg_o !== S0) begin errors++; $display("FAIL idle_ones got=%b exp=%b", seg_o, S0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_blank got=%0d exp=0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_255();
    int bc;
    convert(8'd255, bc);
    checks++; if (bc !== 9) begin errors++; $display("FAIL busy_len got=%0d exp=9", bc); end
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b111) begin errors++; $display("FAIL p255_slots got=%b exp=111", {seen_h, seen_t, seen_o}); end
    checks++; if (seg_h !== S2) begin errors++; $display("FAIL p255_h got=%b exp=%b", seg_h, S2); end
    checks++; if (seg_t !== S5) begin errors++; $display("FAIL p255_t got=%b exp=%b", seg_t, S5); end
    checks++; if (seg_o !== S5) begin errors++; $display("FAIL p255_o got=%b exp=%b", seg_o, S5); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL p255_bad got=%0d exp=0", bad); end
  endtask

  task automatic test_small();
    int bc;
    convert(8'd7, bc);
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b001) begin errors++; $display("FAIL p7_slots got=%b exp=001", {seen_h, seen_t, seen_o}); end
    checks++; if (seg_o !== S7) begin errors++; $display("FAIL p7_o got=%b exp=%b", seg_o, S7); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL p7_blank got=%0d exp=0", bad); end
  endtask

  task automatic test_100();
    int bc;
    convert(8'd100, bc);
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b111) begin errors++; $display("FAIL p100_slots got=%b exp=111", {seen_h, seen_t, seen_o}); end
    checks++; if ({seg_h, seg_t, seg_o} !== {S1, S0, S0}) begin errors++; $display("FAIL p100_digits got=%b_%b_%b exp=%b_%b_%b", seg_h, seg_t, seg_o, S1, S0, S0); end
  endtask

  task automatic test_held_done();
    int rises;
    logic prev;
    rises = 0; prev = busy;
    @(negedge clk);
    P = 8'd37; done = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 5) P = 8'd99;
      if (busy && !prev) rises++;
      prev = busy;
    end
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL held_conversions got=%0d exp=1", rises); end
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b011) begin errors++; $display("FAIL held_slots got=%b exp=011", {seen_h, seen_t, seen_o}); end
    checks++; if ({seg_t, seg_o} !== {S3, S7}) begin errors++; $display("FAIL held_value got=%b_%b exp=%b_%b", seg_t, seg_o, S3, S7); end
  endtask

  task automatic test_back_to_back();
    int bc;
    bc = 0;
    @(negedge clk);
    P = 8'd50; done = 1'b1;
    @(negedge clk); done = 1'b0; if (busy) bc++;
    @(negedge clk); done = 1'b1; P = 8'd88; if (busy) bc++;
    @(negedge clk); done = 1'b0; if (busy) bc++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    checks++; if (bc !== 9) begin errors++; $display("FAIL ignored_rise_busy got=%0d exp=9", bc); end
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b011) begin errors++; $display("FAIL b2b_slots got=%b exp=011", {seen_h, seen_t, seen_o}); end
    checks++; if ({seg_t, seg_o} !== {S5, S0}) begin errors++; $display("FAIL b2b_value got=%b_%b exp=%b_%b", seg_t, seg_o, S5, S0); end
  endtask

  task automatic test_abort();
    int bc;
    @(negedge clk);
    P = 8'd200; done = 1'b1;          // start sampled at edge k
    @(negedge clk); done = 1'b0;      // after k
    @(negedge clk); @(negedge clk); @(negedge clk);   // after k+3
    CLR = 1'b1;
    @(negedge clk);                   // after k+4
    CLR = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if ({an, seg} !== {4'b1110, S0}) begin errors++; $display("FAIL abort_disp got=%b_%b exp=1110_%b", an, seg, S0); end
    observe();
    checks++; if ({seen_h, seen_t, seen_o} !== 3'b001) begin errors++; $display("FAIL abort_slots got=%b exp=001", {seen_h, seen_t, seen_o}); end
    checks++; if (seg_o !== S0) begin errors++; $display("FAIL abort_ones got=%b exp=%b", seg_o, S0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
    convert(8'd125, bc);
    checks++; if (bc !== 9) begin errors++; $display("FAIL post_abort_busy got=%0d exp=9", bc); end
    observe();
    checks++; if ({seg_h, seg_t, seg_o} !== {S1, S2, S5}) begin errors++; $display("FAIL post_abort_value got=%b_%b_%b exp=%b_%b_%b", seg_h, seg_t, seg_o, S1, S2, S5); end
  endtask

  initial begin
    test_reset();
    test_255();
    test_small();
    test_100();
    test_held_done();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
